// File: rtl/johnson_decoder.sv
// Johnson-code receiver: legality check, index decode, successor tracking,
// lock FSM and a saturating error counter. All outputs are registered.
module johnson_decoder #(
  parameter  int WIDTH      = 4,
  parameter  int LOCK_CNT   = 4,
  parameter  int ALLOW_HOLD = 0,
  localparam int IDX_W      = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Code_in,
  input  logic             Code_valid,
  input  logic             Err_clr,
  output logic [IDX_W-1:0] Index_out,
  output logic             Index_valid,
  output logic             Code_err,
  output logic             Step_err,
  output logic             Locked,
  output logic [7:0]       Err_count
);
  localparam int         N      = 2*WIDTH;
  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ref_q, ref_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ival_d, cerr_d, serr_d;
  logic [7:0]       errc_d;

  // Adjacent-bit transitions: a Johnson code has at most one.
  logic [WIDTH-2:0] trans;
  logic             legal;
  logic [IDX_W-1:0] pop, idx, succ;
  logic [IDX_W:0]   mirror;

  assign trans  = Code_in[WIDTH-1:1] ^ Code_in[WIDTH-2:0];
  assign legal  = (trans & (trans - (WIDTH-1)'(1))) == '0;
  assign mirror = (IDX_W+1)'(N) - {1'b0, pop};
  assign idx    = Code_in[WIDTH-1] ? mirror[IDX_W-1:0] : pop;
  assign succ   = (ref_q == IDX_W'(N-1)) ? '0 : ref_q + IDX_W'(1);

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + IDX_W'(Code_in[i]);
  end

  // A valid reference exists exactly when the FSM has left UNLOCKED.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ival_d  = 1'b0;
    cerr_d  = 1'b0;
    serr_d  = 1'b0;
    if (Code_valid) begin
      if (!legal) begin
        cerr_d  = 1'b1;
        state_d = UNLOCKED;
        cnt_d   = '0;
      end else if (state_q == UNLOCKED) begin
        idx_d   = idx;
        ival_d  = 1'b1;
        ref_d   = idx;
        cnt_d   = '0;
        state_d = ACQUIRE;
      end else if (idx == succ) begin
        idx_d  = idx;
        ival_d = 1'b1;
        ref_d  = idx;
        if (cnt_q < LOCK_C) cnt_d = cnt_q + 4'd1;
        if (state_q == ACQUIRE && (cnt_q + 4'd1) == LOCK_C) state_d = LOCKED;
      end else if (ALLOW_HOLD != 0 && idx == ref_q) begin
        idx_d  = idx;
        ival_d = 1'b1;
      end else begin
        serr_d  = 1'b1;
        idx_d   = idx;
        ival_d  = 1'b1;
        ref_d   = idx;
        cnt_d   = '0;
        state_d = ACQUIRE;
      end
    end
    errc_d = Err_count;
    if (Err_clr)                                  errc_d = '0;
    else if ((cerr_d || serr_d) && Err_count != 8'hFF) errc_d = Err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= UNLOCKED;
      ref_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      Index_valid <= 1'b0;
      Code_err    <= 1'b0;
      Step_err    <= 1'b0;
      Err_count   <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      Index_valid <= ival_d;
      Code_err    <= cerr_d;
      Step_err    <= serr_d;
      Err_count   <= errc_d;
    end
  end

  assign Index_out = idx_q;
  assign Locked    = (state_q == LOCKED);

endmodule
